codec_cfg_seq: RTL and testbench
================================

Name: codec_cfg_seq

Overview:
Parametrised codec register-configuration sequencer: after power-up delay, walks a register table and issues one 16-bit {addr,data} word per I2C transaction to the I2C master.
Adds NACK retry with error reporting and run-time headphone/speaker volume updates after initial configuration.
Sits between system reset/control logic and the I2C master driving the WM8978, in the 1 MHz I2C clock domain.

Parameters:
ADDR_W, 7, register address width
DATA_W, 9, register data width; ADDR_W+DATA_W must equal 16
WL, 32, audio word length (16/20/24/32 -> R4 wl field 0/1/2/3; other values -> 0)
START_DLY, 255, power-up wait in clk cycles before first transaction
MAX_RETRY, 3, retries per register after NACK before error (1..7)
PHONE_VOL_DEF, 30, reset value of headphone volume (6 bit)
SPEAK_VOL_DEF, 45, reset value of speaker volume (6 bit)
TIMEOUT, 1000, cycles to wait for i2c_done (only with CFG_TIMEOUT_EN)

Ports:
clk  in  1  I2C driver clock (1 MHz)
sys_rst  in  1  asynchronous active-low reset
i2c_done  in  1  one-cycle pulse: transaction finished
i2c_nack  in  1  valid with i2c_done: 1 = slave did not acknowledge
vol_upd_req  in  1  one-cycle pulse: rewrite volume registers
phone_vol  in  6  new headphone volume, sampled on accepted vol_upd_req
speak_vol  in  6  new speaker volume, sampled on accepted vol_upd_req
i2c_exec  out  1  one-cycle pulse: start transaction with i2c_data
i2c_data  out  16  {register address, register data}
cfg_done  out  1  initial table written successfully (sticky)
cfg_err  out  1  retries exhausted (sticky until reset)
busy  out  1  sequence in progress
vol_upd_ack  out  1  one-cycle pulse: volume update completed

Behaviour:
- Reset: all outputs 0; state WAIT; idx=0; retry_cnt=0; vol regs = *_DEF; delay counter 0.
- Table: 19 entries idx 0..18 = R0,R1,R2,R3,R4,R6,R7,R10,R14,R43,R47..R55, WM8978 init values; R4 data {2'b00,wl,5'b10000}; idx 15/16 use {3'b010/3'b110,phone_vol_q}, idx 17/18 use {3'b010/3'b110,speak_vol_q}.
- WAIT: counter increments each cycle; on reaching START_DLY-1 -> ISSUE. busy=1.
- ISSUE (1 cycle): i2c_data <= table[idx], i2c_exec=1 for exactly this cycle -> WAIT_DONE.
- WAIT_DONE: i2c_data held stable. On i2c_done:
  - nack=0: retry_cnt=0; if idx==last -> IDLE, else idx+1 -> ISSUE.
  - nack=1: if retry_cnt==MAX_RETRY -> ERR, else retry_cnt+1, same idx -> ISSUE.
- Latency: next i2c_exec exactly 2 cycles after i2c_done (done cycle, then ISSUE).
- Initial pass ends at idx 18: entering IDLE sets cfg_done=1, busy=0.
- IDLE: vol_upd_req=1 -> latch phone_vol/speak_vol into *_q, idx=15, busy=1 -> ISSUE; last=18. Completion -> IDLE, vol_upd_ack pulses 1 cycle on entry.
- ERR: terminal; cfg_err=1, busy=0, no i2c_exec; vol_upd_req ignored. Exit only by reset.
- vol_upd_req outside IDLE: ignored (no queueing). i2c_done outside WAIT_DONE: ignored.
- Reset asserted mid-transaction: immediate return to reset state; full sequence restarts with fresh START_DLY.

Optional Feature:
CFG_TIMEOUT_EN: defined -> watchdog counts cycles in WAIT_DONE; reaching TIMEOUT with no i2c_done is treated as i2c_done with nack=1 (same retry/ERR path), counter clears on every ISSUE. Undefined -> WAIT_DONE waits indefinitely; TIMEOUT unused.

Decomposition:
- Package codec_cfg_pkg: state encoding (WAIT, ISSUE, WAIT_DONE, IDLE, ERR), register address constants, table length 19, volume index range 15..18, wl encoding function.
- Sub-module codec_cfg_rom: combinational idx -> 16-bit word, inputs idx, wl, phone_vol_q, speak_vol_q.

Test Plan:
- Reset release, i2c_done 3 cycles after each exec, nack=0 -> first exec at cycle 255; 19 words starting 0x0001, R4 = 0x0870 (WL=32); cfg_done after 19th done; busy falls.
- NACK on idx 5 twice, then ack -> 0x0C01 issued three times, sequence continues, cfg_err=0.
- NACK 4x on idx 2 (MAX_RETRY=3) -> ERR after 4th done, cfg_err=1, no further exec, later vol_upd_req ignored.
- After cfg_done, vol_upd_req with phone_vol=20, speak_vol=50 -> words 0x6894, 0x6B94, 0x6CB2, 0x6FB2, then vol_upd_ack pulse.
- vol_upd_req during initial pass, and reset asserted at idx 10 -> request ignored; after reset, sequence restarts from idx 0 with 255-cycle delay.
- CFG_TIMEOUT_EN, no i2c_done -> re-exec every TIMEOUT+1 cycles; cfg_err after 4 attempts.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared FSM states, WM8978 register table and word-length encoding
// for the codec configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {S_WAIT, S_ISSUE, S_WAIT_DONE, S_IDLE, S_ERR} state_t;

    localparam int TBL_LEN   = 19;
    localparam int VOL_FIRST = 15;
    localparam int VOL_LAST  = 18;

    localparam logic [6:0] REG_ADDR [TBL_LEN] = '{
        7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd6, 7'd7, 7'd10, 7'd14, 7'd43,
        7'd47, 7'd48, 7'd49, 7'd50, 7'd51, 7'd52, 7'd53, 7'd54, 7'd55
    };

    // Entries 4 and 15..18 are built at run time from wl and the volume registers.
    localparam logic [8:0] REG_DATA [TBL_LEN] = '{
        9'h001, 9'h1BF, 9'h1BF, 9'h06F, 9'h000, 9'h001, 9'h000, 9'h008, 9'h108, 9'h010,
        9'h100, 9'h100, 9'h002, 9'h001, 9'h001, 9'h000, 9'h000, 9'h000, 9'h000
    };

    function automatic logic [1:0] wl_enc(input int wl);
        return wl == 16 ? 2'd0 : wl == 20 ? 2'd1 : wl == 24 ? 2'd2 : wl == 32 ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: combinational table index -> {register address, register data} word.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 9
) (
    input  logic [4:0]  idx_i,
    input  logic [1:0]  wl_i,
    input  logic [5:0]  phone_vol_i,
    input  logic [5:0]  speak_vol_i,
    output logic [15:0] word_o
);

    logic [6:0] addr;
    logic [8:0] data;

    // Odd volume registers carry the update bit so left/right latch together.
    always_comb begin
        addr   = idx_i < 5'(TBL_LEN) ? REG_ADDR[idx_i] : 7'd0;
        data   = idx_i == 5'd4  ? {2'b00, wl_i, 5'b10000} :
                 idx_i == 5'd15 ? {3'b010, phone_vol_i} :
                 idx_i == 5'd16 ? {3'b110, phone_vol_i} :
                 idx_i == 5'd17 ? {3'b010, speak_vol_i} :
                 idx_i == 5'd18 ? {3'b110, speak_vol_i} :
                 idx_i < 5'(TBL_LEN) ? REG_DATA[idx_i] : 9'd0;
        word_o = {ADDR_W'(addr), DATA_W'(data)};
    end

endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: WM8978 register-table sequencer with NACK retry and run-time volume rewrite.
// Optional CFG_TIMEOUT_EN adds a WAIT_DONE watchdog that treats a missing i2c_done as a NACK.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 9,
    parameter int WL            = 32,
    parameter int START_DLY     = 255,
    parameter int MAX_RETRY     = 3,
    parameter int PHONE_VOL_DEF = 30,
    parameter int SPEAK_VOL_DEF = 45
`ifdef CFG_TIMEOUT_EN
    ,
    parameter int TIMEOUT       = 1000
`endif
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic        vol_upd_req,
    input  logic [5:0]  phone_vol,
    input  logic [5:0]  speak_vol,
    output logic        i2c_exec,
    output logic [15:0] i2c_data,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        busy,
    output logic        vol_upd_ack
);

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [2:0]  retry_q;
    logic [15:0] dly_q;
    logic [5:0]  phone_q;
    logic [5:0]  speak_q;
    logic [15:0] data_q;
    logic [15:0] word;
    logic        exec_q;
    logic        cfg_done_q;
    logic        cfg_err_q;
    logic        busy_q;
    logic        ack_q;
    logic        done_ev;
    logic        nack_ev;

    codec_cfg_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .idx_i       (idx_q),
        .wl_i        (wl_enc(WL)),
        .phone_vol_i (phone_q),
        .speak_vol_i (speak_q),
        .word_o      (word)
    );

`ifdef CFG_TIMEOUT_EN
    logic [15:0] wd_q;
    assign done_ev = i2c_done || wd_q == 16'(TIMEOUT - 1);
    assign nack_ev = i2c_nack || !i2c_done;
`else
    assign done_ev = i2c_done;
    assign nack_ev = i2c_nack;
`endif

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= S_WAIT;
            idx_q      <= 5'd0;
            retry_q    <= 3'd0;
            dly_q      <= 16'd0;
            phone_q    <= 6'(PHONE_VOL_DEF);
            speak_q    <= 6'(SPEAK_VOL_DEF);
            data_q     <= 16'd0;
            exec_q     <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
`ifdef CFG_TIMEOUT_EN
            wd_q       <= 16'd0;
`endif
        end else begin
            exec_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    busy_q <= 1'b1;
                    dly_q  <= dly_q + 16'd1;
                    if (dly_q == 16'(START_DLY - 1)) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    data_q  <= word;
                    exec_q  <= 1'b1;
                    state_q <= S_WAIT_DONE;
`ifdef CFG_TIMEOUT_EN
                    wd_q    <= 16'd0;
`endif
                end
                S_WAIT_DONE: begin
                    if (done_ev && !nack_ev) begin
                        retry_q <= 3'd0;
                        if (idx_q == 5'(VOL_LAST)) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            cfg_done_q <= 1'b1;
                            // Only a pass started from IDLE (a volume rewrite) is acknowledged.
                            ack_q      <= cfg_done_q;
                        end else begin
                            idx_q   <= idx_q + 5'd1;
                            state_q <= S_ISSUE;
                        end
                    end else if (done_ev && retry_q == 3'(MAX_RETRY)) begin
                        state_q   <= S_ERR;
                        cfg_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (done_ev) begin
                        retry_q <= retry_q + 3'd1;
                        state_q <= S_ISSUE;
                    end
`ifdef CFG_TIMEOUT_EN
                    wd_q <= wd_q + 16'd1;
`endif
                end
                S_IDLE: begin
                    if (vol_upd_req) begin
                        phone_q <= phone_vol;
                        speak_q <= speak_vol;
                        idx_q   <= 5'(VOL_FIRST);
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_exec    = exec_q;
    assign i2c_data    = data_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;
    assign busy        = busy_q;
    assign vol_upd_ack = ack_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: randomized I2C responder plus a transaction-level model of the
// configuration sequencer; the CFG_TIMEOUT_EN scenario runs only when that macro is defined.
module tb_codec_cfg_seq;

    localparam int START_DLY = 255;
    localparam int MAX_RETRY = 3;
    localparam int WL        = 32;
    localparam int TIMEOUT   = 1000;
    localparam int WLC       = WL == 16 ? 0 : WL == 20 ? 1 : WL == 24 ? 2 : WL == 32 ? 3 : 0;
    localparam int ADDRS [19] = '{0, 1, 2, 3, 4, 6, 7, 10, 14, 43, 47, 48, 49, 50, 51, 52, 53, 54, 55};
    localparam int DATS  [19] = '{'h001, 'h1BF, 'h1BF, 'h06F, 0, 'h001, 'h000, 'h008, 'h108, 'h010,
                                  'h100, 'h100, 'h002, 'h001, 'h001, 0, 0, 0, 0};
    localparam int EV_BUSY = 1;
    localparam int EV_IDLE = 2;
    localparam int EV_ERR  = 3;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        vol_upd_req = 1'b0;
    logic [5:0]  phone_vol = 6'd0;
    logic [5:0]  speak_vol = 6'd0;
    logic        i2c_exec, cfg_done, cfg_err, busy, vol_upd_ack;
    logic [15:0] i2c_data;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int m_exec_at, m_done_at, m_vdone_at, m_evt_at, m_evt, m_ack_at;
    int m_attempt, m_pos, m_pv, m_sv, m_fixed_dly, r0, first_exec, ack_seen;
    bit m_busy, m_cfg_done, m_err, m_awaiting, m_upd, m_silent;
    logic [15:0] m_cur;
    logic [15:0] m_seq[$];
    logic [15:0] log_q[$];
    int m_plan[19];

    codec_cfg_seq #(
        .WL(WL), .START_DLY(START_DLY), .MAX_RETRY(MAX_RETRY),
        .PHONE_VOL_DEF(30), .SPEAK_VOL_DEF(45)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .vol_upd_req(vol_upd_req), .phone_vol(phone_vol), .speak_vol(speak_vol),
        .i2c_exec(i2c_exec), .i2c_data(i2c_data), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .busy(busy), .vol_upd_ack(vol_upd_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register word = address * 512 + data, with the run-time fields filled in arithmetically.
    function automatic logic [15:0] tbl(int i, int pv, int sv);
        int d;
        d = i == 4 ? WLC * 32 + 16 : i == 15 ? 128 + pv : i == 16 ? 384 + pv :
            i == 17 ? 128 + sv : i == 18 ? 384 + sv : DATS[i];
        return 16'(ADDRS[i] * 512 + d);
    endfunction

    task automatic report(string nm, int act, int exp);
        errors++;
        if (errors <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) report(nm, int'(act), int'(exp));
    endtask

    task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) report(nm, int'(act), int'(exp));
    endtask

    task automatic chkn(string nm, int act, int exp);
        checks++;
        if (act != exp) report(nm, act, exp);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 19; i++) m_plan[i] = 0;
    endtask

    task automatic resolve(input logic nack);
        m_awaiting = 0;
        m_done_at  = -1;
        m_vdone_at = -1;
        if (nack) begin
            m_attempt++;
            if (m_attempt > MAX_RETRY) begin
                m_evt_at = cyc + 1;
                m_evt    = EV_ERR;
            end else m_exec_at = cyc + 2;
        end else begin
            m_attempt = 0;
            void'(m_seq.pop_front());
            m_pos++;
            if (m_seq.size() == 0) begin
                m_evt_at = cyc + 1;
                m_evt    = EV_IDLE;
            end else m_exec_at = cyc + 2;
        end
    endtask

    // One clock: compare every output against the model, then act as the I2C master.
    task automatic tick();
        @(negedge clk);
        if (cyc == m_evt_at) begin
            if (m_evt == EV_BUSY) m_busy = 1;
            else begin
                m_busy = 0;
                if (m_evt == EV_ERR) m_err = 1;
                else begin
                    m_cfg_done = 1;
                    if (m_upd) m_ack_at = cyc;
                end
            end
            m_evt_at = -1;
        end
        chk1("i2c_exec", i2c_exec, cyc == m_exec_at);
        chk1("busy", busy, m_busy);
        chk1("cfg_done", cfg_done, m_cfg_done);
        chk1("cfg_err", cfg_err, m_err);
        chk1("vol_upd_ack", vol_upd_ack, cyc == m_ack_at);
        if (cyc == m_exec_at) chk16("i2c_data at exec", i2c_data, m_seq[0]);
        else if (m_awaiting) chk16("i2c_data held", i2c_data, m_cur);
        if (i2c_exec) begin
            if (log_q.size() == 0) first_exec = cyc;
            log_q.push_back(i2c_data);
        end
        if (vol_upd_ack) ack_seen++;
        if (cyc == m_exec_at) begin
            m_exec_at  = -1;
            m_cur      = m_seq[0];
            m_awaiting = 1;
            m_done_at  = m_silent ? -1 : cyc + (m_fixed_dly > 0 ? m_fixed_dly : int'($urandom_range(1, 5)));
            m_vdone_at = m_silent ? cyc + TIMEOUT - 1 : -1;
        end
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (cyc == m_done_at) begin
            i2c_done = 1'b1;
            i2c_nack = m_attempt < m_plan[m_pos];
            resolve(i2c_nack);
        end else if (!m_awaiting && $urandom_range(0, 7) == 0) begin
            i2c_done = 1'b1;
            i2c_nack = 1'($urandom);
        end
        if (cyc == m_vdone_at) resolve(1'b1);
    endtask

    task automatic do_reset(int hold);
        sys_rst = 1'b0;
        m_exec_at = -1; m_done_at = -1; m_vdone_at = -1; m_evt_at = -1; m_ack_at = -1;
        m_busy = 0; m_cfg_done = 0; m_err = 0; m_awaiting = 0; m_upd = 0;
        m_pv = 30; m_sv = 45; m_attempt = 0; m_pos = 0;
        repeat (hold) tick();
        sys_rst   = 1'b1;
        r0        = cyc;
        m_exec_at = cyc + START_DLY + 1;
        m_evt_at  = cyc + 1;
        m_evt     = EV_BUSY;
        m_seq.delete();
        for (int i = 0; i < 19; i++) m_seq.push_back(tbl(i, m_pv, m_sv));
        log_q.delete();
    endtask

    task automatic vol_req(logic [5:0] pv, logic [5:0] sv);
        vol_upd_req = 1'b1;
        phone_vol   = pv;
        speak_vol   = sv;
        if (m_cfg_done && !m_busy && !m_err) begin
            m_upd = 1; m_pv = pv; m_sv = sv; m_pos = 15; m_attempt = 0;
            m_seq.delete();
            for (int i = 15; i < 19; i++) m_seq.push_back(tbl(i, pv, sv));
            m_exec_at = cyc + 2;
            m_evt_at  = cyc + 1;
            m_evt     = EV_BUSY;
        end
        tick();
        vol_upd_req = 1'b0;
        phone_vol   = 6'($urandom);
        speak_vol   = 6'($urandom);
    endtask

    task automatic run_quiet(int budget);
        int n = 0;
        while (!(m_err || (m_cfg_done && !m_busy && m_evt_at < 0)) && n < budget) begin
            tick();
            n++;
        end
        chk1("run within budget", n < budget, 1'b1);
    endtask

    task automatic run_to_words(int cnt, int budget);
        int n = 0;
        while (log_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        chk1("word count reached", n < budget, 1'b1);
    endtask

    initial begin
        int c6;
        ack_seen = 0; m_silent = 0; m_fixed_dly = 3;
        clear_plan();

        do_reset(3);
        run_quiet(2000);
        chkn("pass1 word count", log_q.size(), 19);
        chkn("pass1 first exec latency", first_exec - r0, 256);
        if (log_q.size() == 19) begin
            chk16("pass1 R0", log_q[0], 16'h0001);
            chk16("pass1 R4", log_q[4], 16'h0870);
            chk16("pass1 R6", log_q[5], 16'h0C01);
            chk16("pass1 R52 default", log_q[15], 16'h689E);
            chk16("pass1 R55 default", log_q[18], 16'h6FAD);
        end
        m_fixed_dly = 0;

        do_reset(2);
        m_plan[5] = 2;
        repeat (100) tick();
        vol_req(6'd7, 6'd9);
        run_to_words(12, 600);
        vol_req(6'd7, 6'd9);
        run_quiet(2000);
        c6 = 0;
        foreach (log_q[i]) if (log_q[i] == 16'h0C01) c6++;
        chkn("R6 nack retries", c6, 3);
        chkn("pass2 word count", log_q.size(), 21);
        if (log_q.size() == 21) chk16("ignored req left R52", log_q[17], 16'h689E);
        chk1("pass2 cfg_err", cfg_err, 1'b0);

        log_q.delete();
        ack_seen = 0;
        vol_req(6'd20, 6'd50);
        run_quiet(500);
        chkn("vol update word count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk16("vol R52", log_q[0], 16'h6894);
            chk16("vol R53", log_q[1], 16'h6B94);
            chk16("vol R54", log_q[2], 16'h6CB2);
            chk16("vol R55", log_q[3], 16'h6FB2);
        end
        repeat (3) tick();
        chkn("vol ack pulses", ack_seen, 1);

        for (int k = 0; k < 6; k++) begin
            for (int i = 15; i < 19; i++) m_plan[i] = $urandom_range(0, 2);
            repeat ($urandom_range(0, 4)) tick();
            vol_req(6'($urandom), 6'($urandom));
            run_quiet(600);
        end

        do_reset(1);
        clear_plan();
        run_to_words(5, 600);
        vol_req(6'd1, 6'd2);
        run_to_words(11, 300);
        do_reset(2);
        run_quiet(2000);
        chkn("restart first exec latency", first_exec - r0, 256);
        chkn("restart word count", log_q.size(), 19);
        if (log_q.size() > 0) chk16("restart R0", log_q[0], 16'h0001);

        do_reset(2);
        m_plan[2] = 4;
        run_quiet(2000);
        chkn("err word count", log_q.size(), 6);
        chk1("err cfg_err", cfg_err, 1'b1);
        vol_req(6'd5, 6'd5);
        repeat (60) tick();
        chkn("no exec after err", log_q.size(), 6);
        chk1("err busy low", busy, 1'b0);

`ifdef CFG_TIMEOUT_EN
        do_reset(2);
        clear_plan();
        m_silent = 1;
        run_quiet(6000);
        m_silent = 0;
        chkn("timeout attempts", log_q.size(), 4);
        chk1("timeout cfg_err", cfg_err, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
